// File: rtl/mult_acc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult_acc_pkg
//  Description : Shared constants, result type and saturating adder for the
//                multiplier accumulate stage.
//                Contents: default widths, ACC_MAX / ACC_MIN saturation
//                limits, acc_res_t {ovf, data}, sat_add().
//  Revision    : 1.0 - initial release
// ============================================================================
package mult_acc_pkg;

    localparam int ACC_W_DEF   = 40;
    localparam int PROD_W_DEF  = 32;
    localparam int LATENCY_DEF = 2;
    localparam int DEPTH_DEF   = 2;

    localparam logic [ACC_W_DEF-1:0] ACC_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
    localparam logic [ACC_W_DEF-1:0] ACC_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};

    typedef struct packed {
        logic                 ovf;
        logic [ACC_W_DEF-1:0] data;
    } acc_res_t;

    // Signed add with one guard bit; the two top bits disagree exactly when
    // the true sum lies outside the ACC_W_DEF-bit signed range.
    function automatic acc_res_t sat_add(
        input logic [ACC_W_DEF-1:0] a,
        input logic [ACC_W_DEF-1:0] b
    );
        logic [ACC_W_DEF:0] s;
        acc_res_t           r;
        s = {a[ACC_W_DEF-1], a} + {b[ACC_W_DEF-1], b};
        if (s[ACC_W_DEF] != s[ACC_W_DEF-1]) begin
            r.ovf  = 1'b1;
            r.data = s[ACC_W_DEF] ? ACC_MIN : ACC_MAX;
        end else begin
            r.ovf  = 1'b0;
            r.data = s[ACC_W_DEF-1:0];
        end
        return r;
    endfunction

endpackage : mult_acc_pkg
`default_nettype wire

// File: rtl/mult_acc_fifo2.sv
`default_nettype none
// ============================================================================
//  Module      : mult_acc_fifo2
//  Description : DEPTH-entry synchronous FIFO with a register-file head and
//                registered occupancy count.
//                Ports: clk, rst_n (sync, active-low), push_i/push_data_i,
//                pop_i, head_o, valid_o, count_o.
//                head_o/valid_o depend only on registers (no pop_i path).
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_acc_fifo2 #(
    parameter int DATA_W = 41,
    parameter int DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [DATA_W-1:0]          push_data_i,
    input  logic                       pop_i,
    output logic [DATA_W-1:0]          head_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [CNT_W-1:0]  count_q;

    logic w_pop;
    logic w_push;

    // Pop on empty is ignored. A push at full is only taken when the head is
    // leaving in the same cycle, so the slot it overwrites is already freed.
    assign w_pop  = pop_i && (count_q != '0);
    assign w_push = push_i && ((count_q != CNT_W'(DEPTH)) || w_pop);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (w_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (w_push && !w_pop) begin
                count_q <= count_q + 1'b1;
            end else if (w_pop && !w_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

endmodule : mult_acc_fifo2
`default_nettype wire

// File: rtl/mult16s_acc_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mult16s_acc_stage
//  Description : Frame accumulator placed after the registered 16x16 signed
//                multiplier wrapper. Delays a valid/last sideband by LATENCY
//                to line up with product, sums products per frame into a
//                saturating ACC_W accumulator and pushes each frame result
//                into a DEPTH-entry output FIFO. in_ready is a credit check
//                so a push can never find the FIFO full.
//                Ports: clk, rst_n (sync, active-low), in_valid, in_last,
//                in_ready, product, out_valid, out_ready, out_data, out_ovf.
//                ACC_W must equal mult_acc_pkg::ACC_W_DEF (width of sat_add).
//  Revision    : 1.0 - initial release
// ============================================================================
module mult16s_acc_stage
    import mult_acc_pkg::*;
#(
    parameter int PROD_W  = PROD_W_DEF,
    parameter int ACC_W   = ACC_W_DEF,
    parameter int LATENCY = LATENCY_DEF,
    parameter int DEPTH   = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    input  logic [PROD_W-1:0] product,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_ovf
);

    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int CRED_W = $clog2(DEPTH + LATENCY + 1);

    // Sideband delay line; index LATENCY-1 is aligned with product.
    logic [LATENCY-1:0] vld_q,  vld_d;
    logic [LATENCY-1:0] last_q, last_d;

    logic [ACC_W-1:0] acc_q,   acc_d;
    logic             ovf_q,   ovf_d;
    logic             first_q, first_d;

    logic             w_accept;
    logic             w_beat;
    logic             w_beat_last;
    logic [ACC_W-1:0] w_prod_ext;
    logic [ACC_W-1:0] w_base;
    acc_res_t         w_sum;
    logic             w_ovf;
    acc_res_t         w_push_res;
    acc_res_t         w_head;
    logic [CNT_W-1:0] w_fifo_count;
    logic [CRED_W-1:0] w_lasts;
    logic [CRED_W-1:0] w_credit_used;

    // ------------------------------------------------------------------
    // Credit: every last beat still in the delay line owns a FIFO slot.
    // Built from registers only, so out_ready never reaches in_ready.
    // ------------------------------------------------------------------
    always_comb begin
        w_lasts = '0;
        for (int i = 0; i < LATENCY; i++) begin
            w_lasts = w_lasts + CRED_W'(vld_q[i] & last_q[i]);
        end
        w_credit_used = CRED_W'(w_fifo_count) + w_lasts;
    end

    assign in_ready = (w_credit_used < CRED_W'(DEPTH));
    assign w_accept = in_valid & in_ready;

    always_comb begin
        vld_d     = vld_q;
        last_d    = last_q;
        vld_d[0]  = w_accept;
        last_d[0] = in_last;
        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i]  = vld_q[i-1];
            last_d[i] = last_q[i-1];
        end
    end

    // ------------------------------------------------------------------
    // Accumulate on the aligned beat. The first beat of a frame replaces
    // the running sum rather than adding to it, so frames can be packed
    // back to back with no idle cycle.
    // ------------------------------------------------------------------
    assign w_beat      = vld_q[LATENCY-1];
    assign w_beat_last = last_q[LATENCY-1];
    assign w_prod_ext  = ACC_W'(signed'(product));
    assign w_base      = first_q ? '0 : acc_q;
    assign w_sum       = sat_add(w_base, w_prod_ext);
    assign w_ovf       = (!first_q & ovf_q) | w_sum.ovf;

    always_comb begin
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        first_d = first_q;
        if (w_beat) begin
            acc_d   = w_sum.data;
            ovf_d   = w_ovf;
            first_d = w_beat_last;
        end
    end

    always_comb begin
        w_push_res      = '0;
        w_push_res.data = w_sum.data;
        w_push_res.ovf  = w_ovf;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q   <= '0;
            last_q  <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            first_q <= 1'b1;
        end else begin
            vld_q   <= vld_d;
            last_q  <= last_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            first_q <= first_d;
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    mult_acc_fifo2 #(
        .DATA_W ($bits(acc_res_t)),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (w_beat & w_beat_last),
        .push_data_i (w_push_res),
        .pop_i       (out_ready),
        .head_o      (w_head),
        .valid_o     (out_valid),
        .count_o     (w_fifo_count)
    );

    assign out_data = w_head.data;
    assign out_ovf  = w_head.ovf;

endmodule : mult16s_acc_stage
`default_nettype wire

// File: tb/tb_mult16s_acc_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult16s_acc_stage
//  Description : Directed self-checking bench for mult16s_acc_stage with a
//                behavioural 2-cycle registered 16x16 signed multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult16s_acc_stage;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_last;
    logic               in_ready;
    logic               out_valid;
    logic               out_ready;
    logic [39:0]        out_data;
    logic               out_ovf;
    logic signed [15:0] a;
    logic signed [15:0] b;
    logic signed [31:0] p1_q;
    logic signed [31:0] product;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Free-running multiplier: operands in cycle t, product valid in t+2.
    always @(posedge clk) begin
        p1_q    <= a * b;
        product <= p1_q;
    end

    mult16s_acc_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .product   (product),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one beat and hold it until accepted (bounded).
    task automatic beat(input logic signed [15:0] av, input logic signed [15:0] bv, input logic lst);
        int n;
        a        = av;
        b        = bv;
        in_last  = lst;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("beat_accept_timeout", {63'd0, in_ready}, 64'd1);
        tick();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        a        = 16'sd100;
        b        = -16'sd7;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk(tag, {63'd0, out_valid}, 64'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b0;
        idle();
        a = 16'sd0;
        b = 16'sd0;
        repeat (3) tick();

        // Reset state
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_data",  {24'd0, out_data},  64'd0);
        chk("rst_out_ovf",   {63'd0, out_ovf},   64'd0);
        chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
        rst_n = 1'b1;
        tick();

        // Basic frame: 12 - 30 - 14 = -32, result 3 cycles after last accept
        out_ready = 1'b1;
        beat(16'sd3, 16'sd4, 1'b0);
        beat(-16'sd5, 16'sd6, 1'b0);
        beat(16'sd7, -16'sd2, 1'b1);
        idle();
        chk("basic_t1_valid", {63'd0, out_valid}, 64'd0);
        tick();
        chk("basic_t2_valid", {63'd0, out_valid}, 64'd0);
        tick();
        chk("basic_t3_valid", {63'd0, out_valid}, 64'd1);
        chk("basic_data", {24'd0, out_data}, {24'd0, 40'hFF_FFFF_FFE0});
        chk("basic_ovf",  {63'd0, out_ovf},  64'd0);
        tick();
        chk("basic_popped", {63'd0, out_valid}, 64'd0);

        // Back-to-back single-beat frames
        beat(-16'sd32768, -16'sd32768, 1'b1);
        beat(16'sd1, 16'sd1, 1'b1);
        idle();
        tick();
        chk("b2b_r0_valid", {63'd0, out_valid}, 64'd1);
        chk("b2b_r0_data",  {24'd0, out_data},  {24'd0, 40'h00_4000_0000});
        tick();
        chk("b2b_r1_valid", {63'd0, out_valid}, 64'd1);
        chk("b2b_r1_data",  {24'd0, out_data},  64'd1);
        tick();
        chk("b2b_empty", {63'd0, out_valid}, 64'd0);

        // Saturation: 600 x 2^30 exceeds 2^39-1
        for (int i = 0; i < 599; i++) beat(-16'sd32768, -16'sd32768, 1'b0);
        beat(-16'sd32768, -16'sd32768, 1'b1);
        idle();
        wait_valid("sat_valid");
        chk("sat_data", {24'd0, out_data}, {24'd0, 40'h7F_FFFF_FFFF});
        chk("sat_ovf",  {63'd0, out_ovf},  64'd1);
        tick();
        beat(16'sd2, 16'sd3, 1'b1);
        idle();
        wait_valid("after_sat_valid");
        chk("after_sat_data", {24'd0, out_data}, 64'd6);
        chk("after_sat_ovf",  {63'd0, out_ovf},  64'd0);
        tick();
        repeat (2) tick();

        // Backpressure: three single-beat frames, products 1, 2, 3
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_last   = 1'b1;
        a = 16'sd1; b = 16'sd1;
        chk("bp_ready0", {63'd0, in_ready}, 64'd1);
        tick();
        a = 16'sd2;
        chk("bp_ready1", {63'd0, in_ready}, 64'd1);
        tick();
        a = 16'sd3;
        chk("bp_ready_drop", {63'd0, in_ready}, 64'd0);
        tick();
        chk("bp_held_c3", {63'd0, in_ready}, 64'd0);
        tick();
        chk("bp_held_c4", {63'd0, in_ready}, 64'd0);
        chk("bp_head_valid", {63'd0, out_valid}, 64'd1);
        chk("bp_head_data",  {24'd0, out_data},  64'd1);
        tick();
        chk("bp_stable_data", {24'd0, out_data}, 64'd1);
        chk("bp_held_c5", {63'd0, in_ready}, 64'd0);
        out_ready = 1'b1;
        tick();
        chk("bp_ready_rise", {63'd0, in_ready}, 64'd1);
        chk("bp_r2_valid", {63'd0, out_valid}, 64'd1);
        chk("bp_r2_data",  {24'd0, out_data},  64'd2);
        tick();
        idle();
        wait_valid("bp_r3_valid");
        chk("bp_r3_data", {24'd0, out_data}, 64'd3);
        tick();
        chk("bp_empty", {63'd0, out_valid}, 64'd0);

        // Reset mid-frame discards partial sum and in-flight beats
        beat(16'sd5, 16'sd5, 1'b0);
        beat(16'sd5, 16'sd5, 1'b0);
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_in_ready",  {63'd0, in_ready},  64'd1);
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        beat(16'sd1, 16'sd1, 1'b1);
        idle();
        wait_valid("midrst_valid");
        chk("midrst_data", {24'd0, out_data}, 64'd1);
        chk("midrst_ovf",  {63'd0, out_ovf},  64'd0);
        tick();
        repeat (3) tick();
        chk("midrst_no_stale", {63'd0, out_valid}, 64'd0);

        // Invalid gaps between beats: 4 + 9 + 16
        beat(16'sd2, 16'sd2, 1'b0);
        idle();
        repeat (2) tick();
        beat(16'sd3, 16'sd3, 1'b0);
        idle();
        repeat (2) tick();
        beat(16'sd4, 16'sd4, 1'b1);
        idle();
        wait_valid("gap_valid");
        chk("gap_data", {24'd0, out_data}, 64'd29);
        chk("gap_ovf",  {63'd0, out_ovf},  64'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mult16s_acc_stage
`default_nettype wire
